// File: rtl/keypad_msg_tx_buffer.sv
`default_nettype none
// ============================================================================
// keypad_msg_tx_buffer : collects key bytes into an editable message and
// streams it to a byte transmitter over a ready/strobe handshake.
// Revision: 1.0
// ============================================================================
module keypad_msg_tx_buffer #(
  parameter int                DATA_W      = 8,
  parameter int                DEPTH       = 16,
  parameter logic [DATA_W-1:0] SEND_CODE   = 8'h0D,
  parameter logic [DATA_W-1:0] BKSP_CODE   = 8'h08,
  parameter logic [DATA_W-1:0] CLR_CODE    = 8'h1B,
  parameter int                PAD_EN      = 0,
  parameter logic [DATA_W-1:0] PAD_CHAR    = 8'h20,
  parameter int                ACK_TIMEOUT = 15
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic [DATA_W-1:0]          key_data,
  input  logic                       key_valid,
  input  logic                       transmit_ready,
  output logic [DATA_W-1:0]          data_send,
  output logic                       tx_ctrl,
  output logic [$clog2(DEPTH+1)-1:0] msg_count,
  output logic                       full,
  output logic                       busy,
  output logic                       overflow,
  output logic                       done
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  localparam int TW = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    COLLECT  = 2'd0,
    WAIT_RDY = 2'd1,
    WAIT_ACK = 2'd2,
    DONE     = 2'd3
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [DATA_W-1:0] msg_mem [DEPTH];
  logic [IW-1:0]     idx;
  logic [CW-1:0]     len;
  logic [TW-1:0]     timer;

  logic          key_seen;
  logic          is_send;
  logic          is_bksp;
  logic          is_clr;
  logic          is_char;
  logic [CW-1:0] send_len;
  logic          send_go;
  logic          strobe;
  logic          timeout_hit;
  logic          accept;
  logic          last;

  assign full = (msg_count == CW'(DEPTH));
  assign busy = (state != COLLECT);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (!nrst) state <= COLLECT;
    else       state <= next_state;
  end

  always_comb begin
    key_seen    = key_valid && (state == COLLECT);
    is_send     = key_seen && (key_data == SEND_CODE);
    is_bksp     = key_seen && (key_data == BKSP_CODE);
    is_clr      = key_seen && (key_data == CLR_CODE);
    is_char     = key_seen && !is_send && !is_bksp && !is_clr;
    send_len    = (PAD_EN != 0) ? CW'(DEPTH) : msg_count;
    send_go     = is_send && (send_len != '0);
    strobe      = (state == WAIT_RDY) && transmit_ready;
    // A zero timeout means the handshake never self-completes.
    timeout_hit = (ACK_TIMEOUT > 0) && (timer == '0);
    accept      = (state == WAIT_ACK) && (!transmit_ready || timeout_hit);
    last        = (CW'(idx) == (len - CW'(1)));
    next_state  = state;
    case (state)
      COLLECT:  if (send_go) next_state = WAIT_RDY;
      WAIT_RDY: if (transmit_ready) next_state = WAIT_ACK;
      WAIT_ACK: if (accept) next_state = last ? DONE : WAIT_RDY;
      DONE:     next_state = COLLECT;
      default:  next_state = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      msg_count <= '0;
      idx       <= '0;
      len       <= '0;
      timer     <= '0;
      data_send <= '0;
      tx_ctrl   <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      tx_ctrl <= strobe;
      if (strobe) begin
        data_send <= (CW'(idx) < msg_count) ? msg_mem[idx] : PAD_CHAR;
        timer     <= TW'(ACK_TIMEOUT);
      end else if ((state == WAIT_ACK) && (timer != '0)) begin
        timer <= timer - TW'(1);
      end

      if (send_go) begin
        len <= send_len;
        idx <= '0;
      end
      if (accept && !last) idx <= idx + IW'(1);
      if (accept && last) msg_count <= '0;

      if (is_bksp && (msg_count != '0)) msg_count <= msg_count - CW'(1);
      if (is_clr) begin
        msg_count <= '0;
        overflow  <= 1'b0;
      end
      if (is_char) begin
        if (!full) msg_count <= msg_count + CW'(1);
        else       overflow  <= 1'b1;
      end
    end
  end

  // Storage is not reset; msg_count alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (is_char && !full) msg_mem[msg_count[IW-1:0]] <= key_data;
  end

endmodule
`default_nettype wire
